// File: rtl/ov5640_crop.sv
// Crops the assembled OV5640 pixel stream to a fixed window.
// Frames are delivered whole or not at all, framed by sof/eol/eof.
module ov5640_crop #(
  parameter int unsigned SRC_W   = 1024,
  parameter int unsigned SRC_H   = 768,
  parameter int unsigned CROP_X0 = 192,
  parameter int unsigned CROP_Y0 = 144,
  parameter int unsigned CROP_W  = 640,
  parameter int unsigned CROP_H  = 480
) (
  input  logic        ov5640_pclk,
  input  logic        s_rst,
  input  logic        ov5640_vsync,
  input  logic        cap_en,
  input  logic [15:0] s_data,
  input  logic        s_wr_en,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_err
);

  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = $clog2(SRC_H + 1);

  typedef enum logic [1:0] {
    WAIT_VS,
    ACTIVE,
    DONE
  } state_t;

  state_t st, st_n;

  logic          vs_r;
  logic          vs_pos;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [31:0]   xi;
  logic [31:0]   yi;
  logic          x_last;
  logic          y_last;
  logic          in_win;
  logic          acc;
  logic          fwd;
  logic          err_n;

  assign vs_pos = ov5640_vsync & ~vs_r;
  assign xi     = 32'(x_cnt);
  assign yi     = 32'(y_cnt);
  assign x_last = (xi == SRC_W - 1);
  assign y_last = (yi == SRC_H - 1);
  assign in_win = (xi >= CROP_X0) && (xi < CROP_X0 + CROP_W) &&
                  (yi >= CROP_Y0) && (yi < CROP_Y0 + CROP_H);

  // vsync beats a coincident pixel: it is neither counted nor flagged
  assign acc = (st == ACTIVE) & s_wr_en & ~vs_pos;
  assign fwd = acc & in_win;

  always_comb begin
    st_n  = st;
    err_n = 1'b0;
    unique case (st)
      WAIT_VS: begin
        if (vs_pos && cap_en) st_n = ACTIVE;
      end
      ACTIVE: begin
        if (vs_pos) begin
          err_n = 1'b1;
          st_n  = cap_en ? ACTIVE : WAIT_VS;
        end else if (s_wr_en && x_last && y_last) begin
          st_n = DONE;
        end
      end
      DONE: begin
        if (vs_pos) st_n = cap_en ? ACTIVE : WAIT_VS;
        else        err_n = s_wr_en;
      end
      default: st_n = WAIT_VS;
    endcase
  end

  always_ff @(posedge ov5640_pclk) begin
    if (s_rst) begin
      st    <= WAIT_VS;
      vs_r  <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      st   <= st_n;
      vs_r <= ov5640_vsync;
      if (vs_pos) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (acc) begin
        if (x_last) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ov5640_pclk) begin
    if (s_rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= fwd;
      o_err   <= err_n;
      if (fwd) o_data <= s_data;
      o_sof <= fwd && (xi == CROP_X0) && (yi == CROP_Y0);
      o_eol <= fwd && (xi == CROP_X0 + CROP_W - 1);
      o_eof <= fwd && (xi == CROP_X0 + CROP_W - 1) &&
               (yi == CROP_Y0 + CROP_H - 1);
    end
  end

endmodule

// File: tb/tb_ov5640_crop.sv
// Bench for ov5640_crop: random pixels and gaps against a
// frame-index reference model of the crop window.
module tb_ov5640_crop;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int X0 = 2;
  localparam int Y0 = 1;
  localparam int CW = 4;
  localparam int CH = 3;

  logic        clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        ov5640_vsync = 1'b0;
  logic        cap_en = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_wr_en = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_eol;
  logic        o_eof;
  logic        o_err;

  always #5 clk = ~clk;

  ov5640_crop #(
    .SRC_W(W), .SRC_H(H), .CROP_X0(X0), .CROP_Y0(Y0),
    .CROP_W(CW), .CROP_H(CH)
  ) dut (
    .ov5640_pclk (clk),
    .s_rst       (s_rst),
    .ov5640_vsync(ov5640_vsync),
    .cap_en      (cap_en),
    .s_data      (s_data),
    .s_wr_en     (s_wr_en),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_eol       (o_eol),
    .o_eof       (o_eof),
    .o_err       (o_err)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } rec_t;

  rec_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  int   obs_err = 0;
  int   nvalid = 0;
  bit   cap = 0;
  int   k = 0;

  // Reference: a captured frame is a flat index k; pixel k sits at
  // (k mod W, k div W); anything past W*H is an overrun error.
  function automatic void model_pix(input logic [15:0] d);
    int   x;
    int   y;
    rec_t r;
    if (!cap) return;
    if (k < W * H) begin
      x = k % W;
      y = k / W;
      if (x >= X0 && x < X0 + CW && y >= Y0 && y < Y0 + CH) begin
        r.d   = d;
        r.sof = (x == X0) && (y == Y0);
        r.eol = (x == X0 + CW - 1);
        r.eof = r.eol && (y == Y0 + CH - 1);
        expq.push_back(r);
      end
    end else begin
      exp_err++;
    end
    k++;
  endfunction

  always @(negedge clk) begin
    rec_t got;
    rec_t e;
    if (o_err) obs_err++;
    if (o_valid) begin
      nvalid++;
      got = {o_data, o_sof, o_eol, o_eof};
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed=%h expected=none", got);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        assert (got === e) else begin
          errors++;
          $error("FAIL pixel observed=%h expected=%h", got, e);
        end
      end
    end else begin
      checks++;
      assert ({o_sof, o_eol, o_eof} === 3'b000) else begin
        errors++;
        $error("FAIL idle_markers observed=%b expected=000",
               {o_sof, o_eol, o_eof});
      end
    end
  end

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic pixel(input logic [15:0] d);
    @(posedge clk); #1;
    s_wr_en = 1'b1;
    s_data  = d;
    model_pix(d);
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    s_data  = 16'($urandom);
    repeat ($urandom_range(0, 1)) @(posedge clk);
  endtask

  task automatic vsync(input bit ce, input bit wp);
    @(posedge clk); #1;
    ov5640_vsync = 1'b1;
    cap_en  = ce;
    s_wr_en = wp;
    s_data  = 16'($urandom);
    if (cap && k < W * H) exp_err++;
    cap = ce;
    k   = 0;
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    cap_en  = 1'($urandom);
    @(posedge clk); #1;
    ov5640_vsync = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_pixels(input int n);
    for (int i = 0; i < n; i++) pixel(16'($urandom));
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_drain"}, expq.size(), 0);
    check({tag, "_err"}, obs_err, exp_err);
  endtask

  initial begin
    int v0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          int'({o_data, o_valid, o_sof, o_eol, o_eof, o_err}), 0);
    @(posedge clk); #1;
    s_rst = 1'b0;

    // full frame with {y,x} data
    vsync(1'b1, 1'b0);
    v0 = nvalid;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pixel({8'(y), 8'(x)});
    drain("full");
    check("full_count", nvalid - v0, 12);
    check("full_errs", obs_err, 0);

    // disabled at vsync, enable raised mid-frame
    vsync(1'b0, 1'b0);
    v0 = nvalid;
    rand_pixels(20);
    cap_en = 1'b1;
    rand_pixels(28);
    drain("disabled");
    check("disabled_count", nvalid - v0, 0);
    vsync(1'b1, 1'b0);
    rand_pixels(W * H);
    drain("after_dis");

    // short frame then a complete one
    vsync(1'b1, 1'b0);
    rand_pixels(30);
    vsync(1'b1, 1'b0);
    check("short_errs", exp_err, 1);
    rand_pixels(W * H);
    drain("short");

    // overrun: 50 pixels in a 48-pixel frame
    vsync(1'b1, 1'b0);
    v0 = nvalid;
    rand_pixels(50);
    drain("extra");
    check("extra_errs", obs_err, 3);
    check("extra_count", nvalid - v0, 12);

    // vsync coincident with a pixel
    vsync(1'b1, 1'b1);
    rand_pixels(W * H);
    drain("coinc");

    // reset mid-frame
    vsync(1'b1, 1'b0);
    rand_pixels(20);
    @(posedge clk); #1;
    s_rst = 1'b1;
    cap = 0;
    k   = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_outs",
          int'({o_data, o_valid, o_sof, o_eol, o_eof, o_err}), 0);
    @(posedge clk); #1;
    s_rst = 1'b0;
    v0 = nvalid;
    rand_pixels(10);
    drain("post_rst");
    check("post_rst_count", nvalid - v0, 0);
    vsync(1'b1, 1'b0);
    v0 = nvalid;
    rand_pixels(W * H);
    drain("rst_frame");
    check("rst_frame_count", nvalid - v0, 12);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ov5640_crop.md
# ov5640_crop

Downstream stage of the OV5640 byte-pair assembler, in the `ov5640_pclk` domain. It consumes the assembled 16-bit pixel stream (`s_data`/`s_wr_en`) plus the raw sensor `ov5640_vsync`. It tracks the pixel position within the frame and forwards only pixels inside a rectangular crop window, marking start-of-frame, end-of-line and end-of-frame. Output feeds the SDRAM write-side buffer, so captured frames are always whole.

## Interface
- `SRC_W`, 1024: active pixels per sensor line (pixels = `s_wr_en` pulses).
- `SRC_H`, 768: active lines per sensor frame.
- `CROP_X0`, 192: first kept column.
- `CROP_Y0`, 144: first kept line.
- `CROP_W`, 640: kept columns. Requires `CROP_X0+CROP_W <= SRC_W`.
- `CROP_H`, 480: kept lines. Requires `CROP_Y0+CROP_H <= SRC_H`.
- `ov5640_pclk`  in  1  sole clock, all logic on rising edge.
- `s_rst`  in  1  synchronous, active-high reset.
- `ov5640_vsync`  in  1  raw sensor vsync; rising edge = frame boundary.
- `cap_en`  in  1  capture enable; sampled only at vsync rising edge.
- `s_data`  in  16  assembled pixel.
- `s_wr_en`  in  1  `s_data` valid this cycle. Never asserted on two consecutive cycles.
- `o_data`  out  16  cropped pixel.
- `o_valid`  out  1  `o_data` valid.
- `o_sof`  out  1  with `o_valid`: first pixel of cropped frame.
- `o_eol`  out  1  with `o_valid`: last pixel of a cropped line.
- `o_eof`  out  1  with `o_valid`: last pixel of cropped frame.
- `o_err`  out  1  one-cycle pulse on frame length error.

## Operation
- Vsync edge: `vs_r` registers `ov5640_vsync`. `vs_pos = ov5640_vsync & ~vs_r`. `vs_r` is cleared by reset.
- Counters:
  - `x_cnt` is ceil(log2(SRC_W)) bits; `y_cnt` is ceil(log2(SRC_H+1)) bits.
  - Both are zeroed on `vs_pos`.
  - On each accepted `s_wr_en`, `x_cnt` increments. At `SRC_W-1` it wraps to 0 and `y_cnt` increments.
  - `y_cnt` reaching `SRC_H` means the frame is complete.
- In-window test (combinational on current counters): `CROP_X0 <= x_cnt < CROP_X0+CROP_W` and `CROP_Y0 <= y_cnt < CROP_Y0+CROP_H`.
- State machine:
  - WAIT_VS (reset state): pixels ignored. On `vs_pos` with `cap_en=1` go to ACTIVE; with `cap_en=0` stay.
  - ACTIVE: count pixels and forward in-window pixels. On the pixel with `x_cnt=SRC_W-1` and `y_cnt=SRC_H-1`, go to DONE.
    - `vs_pos` in ACTIVE: pulse `o_err`, restart counters, re-evaluate `cap_en` (stay ACTIVE if 1, else go to WAIT_VS).
  - DONE: pixels are not counted or forwarded. Any `s_wr_en` pulses `o_err` (once per pixel). On `vs_pos`, go to ACTIVE if `cap_en=1`, else WAIT_VS; no error.
- Markers, all evaluated on the forwarded pixel:
  - `o_sof` = (x,y) = (`CROP_X0`,`CROP_Y0`).
  - `o_eol` = x = `CROP_X0+CROP_W-1`.
  - `o_eof` = `o_eol` and y = `CROP_Y0+CROP_H-1`.
- `cap_en` changes outside `vs_pos` have no effect; frames are never truncated by the enable.

## Timing
- Reset values: `o_data=0`, `o_valid=0`, `o_sof=0`, `o_eol=0`, `o_eof=0`, `o_err=0`, counters 0, state WAIT_VS.
- Latency: input pixel at edge N produces `o_valid` at edge N+1 (one register stage). `o_data`, `o_sof`, `o_eol` and `o_eof` are aligned with `o_valid`.
- `o_data` holds its last value while `o_valid=0`. Markers are 0 whenever `o_valid=0`.
- `vs_pos` and `s_wr_en` in the same cycle: vsync wins. The pixel is dropped and not counted. The next pixel counts as (0,0).
- `o_err` is registered, asserting one cycle after the causing event, and is independent of `o_valid`.
- Reset asserted mid-frame: outputs clear on the next edge. The rest of that frame is ignored until a new `vs_pos`.
- No back-pressure; downstream must accept one pixel per two cycles sustained.

## Test plan
For all directed tests: `SRC_W=8`, `SRC_H=6`, `CROP_X0=2`, `CROP_Y0=1`, `CROP_W=4`, `CROP_H=3`. Pixel value = `{y,x}`; `s_wr_en` every other cycle.
- Full frame, `cap_en=1`:
  - Exactly 12 `o_valid` pulses, data 0x0102..0x0105, 0x0202..0x0205, 0x0302..0x0305.
  - `o_sof` only on 0x0102; `o_eol` on 0x0105/0x0205/0x0305; `o_eof` only on 0x0305; `o_err` never.
- `cap_en=0` at vsync, raised mid-frame: zero outputs that frame. Next frame is fully captured.
- Short frame (vsync after 30 pixels): one `o_err` pulse. Following frame complete with correct `o_sof`.
- Extra pixels (50 sent before vsync): 2 `o_err` pulses. Output identical to the full-frame case.
- Vsync coincident with a pixel: that pixel is dropped. First counted pixel is (0,0), verified by `o_sof` on the 11th counted pixel.
- `s_rst` pulsed after 20 pixels: all outputs 0 the next cycle. Nothing further is output until the next vsync; then a full 12-pixel frame follows.
